// File: rtl/cr_kme_tx_pkg.sv
// Shared types and default sizes for the KME transmit-side FIFO feeder.
package cr_kme_tx_pkg;

    localparam int DATA_W_DEF = 71;
    localparam int CNT_W_DEF  = 16;

    // Occupancy of the 2-entry skid buffer.
    typedef enum logic [1:0] {
        TX_EMPTY = 2'd0,
        TX_ONE   = 2'd1,
        TX_TWO   = 2'd2
    } tx_state_t;

endpackage

// File: rtl/cr_kme_skid2.sv
// Two-entry skid buffer. The head entry is presented downstream; the tail
// catches the one extra entry that can arrive while the head is blocked,
// which lets the upstream ready be a register rather than a combinational
// function of the downstream stall.
module cr_kme_skid2
    import cr_kme_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_acc,
    input  logic              i_launch,
    output logic [DATA_W-1:0] o_head,
    output logic              o_has_data,
    output logic              o_ready,
    output tx_state_t         o_state
);

    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic [DATA_W-1:0] w_head_nxt;
    logic [DATA_W-1:0] w_tail_nxt;
    logic              r_ready;

    // State, storage and registered ready; ready looks one cycle ahead so it
    // is low exactly when the buffer will be full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TX_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_ready <= (w_state_nxt != TX_TWO);
        end
    end

    // Next-state and storage steering; a launch always retires the head.
    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        case (r_state)
            TX_EMPTY: begin
                if (i_acc) begin
                    w_state_nxt = TX_ONE;
                    w_head_nxt  = i_data;
                end
            end
            TX_ONE: begin
                if (i_acc && i_launch) begin
                    w_head_nxt = i_data;
                end else if (i_acc) begin
                    w_state_nxt = TX_TWO;
                    w_tail_nxt  = i_data;
                end else if (i_launch) begin
                    w_state_nxt = TX_EMPTY;
                end
            end
            TX_TWO: begin
                if (i_launch) begin
                    w_state_nxt = TX_ONE;
                    w_head_nxt  = r_tail;
                end
            end
            default: begin
                w_state_nxt = TX_EMPTY;
            end
        endcase
    end

    assign o_head     = r_head;
    assign o_has_data = (r_state != TX_EMPTY);
    assign o_ready    = r_ready;
    assign o_state    = r_state;

endmodule

// File: rtl/cr_kme_fifo_tx.sv
// Transmit-side feeder for the KME stall-protocol FIFO: buffers upstream
// entries, writes them to the FIFO only when it has room and no hold is
// applied, and counts cycles lost to downstream stall.
//
// Handshakes: upstream transfers an entry on any cycle where src_valid and
// src_ready are both high at the clock edge; src_ready is registered and the
// source must hold src_data/src_valid stable while src_ready is low.
// Downstream, fifo_in_valid is a write strobe that is only raised while
// fifo_in_stall is low, so the FIFO can never be overrun.
module cr_kme_fifo_tx
    import cr_kme_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic              tx_hold,
    output logic [DATA_W-1:0] fifo_in,
    output logic              fifo_in_valid,
    input  logic              fifo_in_stall,
    input  logic              stall_cnt_clr,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             w_acc;
    logic             w_launch;
    logic             w_has_data;
    logic             w_ready;
    tx_state_t        w_state;
    logic [CNT_W-1:0] r_stall_cycles;

    assign w_acc    = src_valid & w_ready;
    assign w_launch = w_has_data & ~fifo_in_stall & ~tx_hold;

    cr_kme_skid2 #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .i_data     (src_data),
        .i_acc      (w_acc),
        .i_launch   (w_launch),
        .o_head     (fifo_in),
        .o_has_data (w_has_data),
        .o_ready    (w_ready),
        .o_state    (w_state)
    );

    // Saturating count of cycles where data was ready but the FIFO was full;
    // cycles under tx_hold are not the FIFO's fault and are not counted.
    always_ff @(posedge clk) begin
        if (rst || stall_cnt_clr) begin
            r_stall_cycles <= '0;
        end else if (w_has_data && fifo_in_stall && !tx_hold &&
                     (r_stall_cycles != CNT_MAX)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign src_ready     = w_ready;
    assign fifo_in_valid = w_launch;
    assign stall_cycles  = r_stall_cycles;
    assign busy          = w_has_data;
    assign dbg_state     = w_state;

endmodule

// File: tb/tb_cr_kme_fifo_tx.sv
// Bench for cr_kme_fifo_tx: directed scenarios plus a long randomized run
// against a queue-based reference model. A second instance with a 4-bit
// counter shares all inputs to exercise counter saturation.
module tb_cr_kme_fifo_tx;

    localparam int DW = 71;

    logic          clk;
    logic          rst;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          tx_hold;
    logic          fifo_in_stall;
    logic          stall_cnt_clr;

    logic          src_ready;
    logic [DW-1:0] fifo_in;
    logic          fifo_in_valid;
    logic [15:0]   stall_cycles;
    logic          busy;
    logic [1:0]    dbg_state;

    logic          b_src_ready;
    logic [DW-1:0] b_fifo_in;
    logic          b_fifo_in_valid;
    logic [3:0]    b_stall_cycles;
    logic          b_busy;
    logic [1:0]    b_dbg_state;

    int checks = 0;
    int errors = 0;

    cr_kme_fifo_tx #(.DATA_W(DW), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .src_data      (src_data),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .tx_hold       (tx_hold),
        .fifo_in       (fifo_in),
        .fifo_in_valid (fifo_in_valid),
        .fifo_in_stall (fifo_in_stall),
        .stall_cnt_clr (stall_cnt_clr),
        .stall_cycles  (stall_cycles),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    cr_kme_fifo_tx #(.DATA_W(DW), .CNT_W(4)) dut4 (
        .clk           (clk),
        .rst           (rst),
        .src_data      (src_data),
        .src_valid     (src_valid),
        .src_ready     (b_src_ready),
        .tx_hold       (tx_hold),
        .fifo_in       (b_fifo_in),
        .fifo_in_valid (b_fifo_in_valid),
        .fifo_in_stall (fifo_in_stall),
        .stall_cnt_clr (stall_cnt_clr),
        .stall_cycles  (b_stall_cycles),
        .busy          (b_busy),
        .dbg_state     (b_dbg_state)
    );

    // Clock and reset defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: inputs change at the falling edge, outputs are sampled 1ns later,
    // well before the next rising edge commits the cycle.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic st,
                         input logic hd, input logic clr);
        @(negedge clk);
        src_valid     = v;
        src_data      = d;
        fifo_in_stall = st;
        tx_hold       = hd;
        stall_cnt_clr = clr;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; src_valid = 1'b0; src_data = '0;
        fifo_in_stall = 1'b0; tx_hold = 1'b0; stall_cnt_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (src_ready !== 1'b1 || fifo_in_valid !== 1'b0 || busy !== 1'b0 ||
            stall_cycles !== 16'd0 || fifo_in !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b busy=%b cnt=%0d data=%h state=%0d want 1 0 0 0 0 0",
                     src_ready, fifo_in_valid, busy, stall_cycles, fifo_in, dbg_state);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            drive(i < 4, DW'(i + 1), 1'b0, 1'b0, 1'b0);
            checks++;
            if (src_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready cycle %0d: got %b want 1", i, src_ready);
            end
            checks++;
            if (fifo_in_valid !== (i >= 1 && i <= 4)) begin
                errors++;
                $display("FAIL b2b_valid cycle %0d: got %b want %b", i, fifo_in_valid, (i >= 1 && i <= 4));
            end
            if (i >= 1 && i <= 4) begin
                checks++;
                if (fifo_in !== DW'(i)) begin
                    errors++;
                    $display("FAIL b2b_data cycle %0d: got %h want %h", i, fifo_in, DW'(i));
                end
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] d;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        // Stall held throughout; 0xA lands in an empty buffer (not counted),
        // then five counted cycles follow with data waiting.
        for (int i = 0; i < 6; i++) begin
            d = (i == 0) ? DW'('hA) : (i == 1) ? DW'('hB) : DW'('hC);
            drive(1'b1, d, 1'b1, 1'b0, 1'b0);
            checks++;
            if (src_ready !== (i < 2)) begin
                errors++;
                $display("FAIL stall_ready cycle %0d: got %b want %b", i, src_ready, (i < 2));
            end
            checks++;
            if (fifo_in_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_valid cycle %0d: got %b want 0", i, fifo_in_valid);
            end
        end
        drive(1'b1, DW'('hC), 1'b0, 1'b0, 1'b0);
        checks++;
        if (stall_cycles !== 16'd5 || b_stall_cycles !== 4'd5) begin
            errors++;
            $display("FAIL stall_count: got %0d/%0d want 5/5", stall_cycles, b_stall_cycles);
        end
        checks++;
        if (src_ready !== 1'b0 || fifo_in_valid !== 1'b1 || fifo_in !== DW'('hA)) begin
            errors++;
            $display("FAIL stall_release_a: ready=%b valid=%b data=%h want 0 1 a", src_ready, fifo_in_valid, fifo_in);
        end
        drive(1'b1, DW'('hC), 1'b0, 1'b0, 1'b0);
        checks++;
        if (src_ready !== 1'b1 || fifo_in_valid !== 1'b1 || fifo_in !== DW'('hB)) begin
            errors++;
            $display("FAIL stall_release_b: ready=%b valid=%b data=%h want 1 1 b", src_ready, fifo_in_valid, fifo_in);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fifo_in_valid !== 1'b1 || fifo_in !== DW'('hC)) begin
            errors++;
            $display("FAIL stall_release_c: valid=%b data=%h want 1 c", fifo_in_valid, fifo_in);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0 || fifo_in_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: busy=%b valid=%b want 0 0", busy, fifo_in_valid);
        end
    endtask

    task automatic test_hold();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, DW'('h7), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
            checks++;
            if (fifo_in_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_block cycle %0d: valid=%b busy=%b want 0 1", i, fifo_in_valid, busy);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL hold_count: got %0d want 0", stall_cycles);
        end
        checks++;
        if (fifo_in_valid !== 1'b1 || fifo_in !== DW'('h7)) begin
            errors++;
            $display("FAIL hold_release: valid=%b data=%h want 1 7", fifo_in_valid, fifo_in);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, DW'('h9), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (i == 16) begin
                checks++;
                if (stall_cycles !== 16'd16 || b_stall_cycles !== 4'd15) begin
                    errors++;
                    $display("FAIL sat_mid: got %0d/%0d want 16/15", stall_cycles, b_stall_cycles);
                end
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (stall_cycles !== 16'd20 || b_stall_cycles !== 4'd15) begin
            errors++;
            $display("FAIL sat_end: got %0d/%0d want 20/15", stall_cycles, b_stall_cycles);
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (stall_cycles !== 16'd0 || b_stall_cycles !== 4'd0) begin
            errors++;
            $display("FAIL sat_clr: got %0d/%0d want 0/0", stall_cycles, b_stall_cycles);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (stall_cycles !== 16'd1 || fifo_in_valid !== 1'b1 || fifo_in !== DW'('h9)) begin
            errors++;
            $display("FAIL sat_release: cnt=%0d valid=%b data=%h want 1 1 9", stall_cycles, fifo_in_valid, fifo_in);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, DW'('h5), 1'b1, 1'b0, 1'b0);
        drive(1'b1, DW'('h6), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; src_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || src_ready !== 1'b0 || fifo_in_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_full: busy=%b ready=%b valid=%b want 1 0 0", busy, src_ready, fifo_in_valid);
        end
        @(negedge clk);
        rst = 1'b0; fifo_in_stall = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || src_ready !== 1'b1 || fifo_in_valid !== 1'b0 || stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL midrst_after: busy=%b ready=%b valid=%b cnt=%0d want 0 1 0 0",
                     busy, src_ready, fifo_in_valid, stall_cycles);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (fifo_in_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_emit cycle %0d: valid=%b data=%h want 0", i, fifo_in_valid, fifo_in);
            end
        end
    endtask

    // Reference model: an ordered queue of accepted entries plus the rules
    // that the source may push only when fewer than two are held (as seen at
    // the start of the cycle) and the oldest leaves whenever the FIFO has room
    // and no hold applies.
    task automatic test_random();
        logic [DW-1:0] exp_q[$];
        logic          m_ready;
        int            m_cnt16;
        int            m_cnt4;
        logic          p_v;
        logic [DW-1:0] p_d;
        logic          keep;
        logic          st, hd, clr, m_acc, m_launch;
        logic [95:0]   r96;
        logic [DW-1:0] exp_head;

        @(negedge clk);
        rst = 1'b1; src_valid = 1'b0; fifo_in_stall = 1'b0; tx_hold = 1'b0; stall_cnt_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1; m_cnt16 = 0; m_cnt4 = 0;
        keep = 1'b0; p_v = 1'b0; p_d = '0;

        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (!keep) begin
                p_v = ($urandom_range(0, 99) < 70);
                r96 = {$urandom, $urandom, $urandom};
                p_d = r96[DW-1:0];
            end
            st  = ($urandom_range(0, 99) < 35);
            hd  = ($urandom_range(0, 99) < 10);
            clr = ($urandom_range(0, 99) < 2);
            drive(p_v, p_d, st, hd, clr);

            m_launch = (exp_q.size() > 0) && !st && !hd;
            m_acc    = p_v && m_ready;
            exp_head = (exp_q.size() > 0) ? exp_q[0] : '0;

            checks++;
            if (src_ready !== m_ready) begin
                errors++;
                $display("FAIL rnd_ready cyc %0d: got %b want %b", cyc, src_ready, m_ready);
            end
            checks++;
            if (fifo_in_valid !== m_launch) begin
                errors++;
                $display("FAIL rnd_valid cyc %0d: got %b want %b", cyc, fifo_in_valid, m_launch);
            end
            if (m_launch) begin
                checks++;
                if (fifo_in !== exp_head) begin
                    errors++;
                    $display("FAIL rnd_data cyc %0d: got %h want %h", cyc, fifo_in, exp_head);
                end
            end
            checks++;
            if (fifo_in_valid === 1'b1 && fifo_in_stall === 1'b1) begin
                errors++;
                $display("FAIL rnd_overrun cyc %0d: valid=1 while stall=1", cyc);
            end
            checks++;
            if (busy !== (exp_q.size() > 0)) begin
                errors++;
                $display("FAIL rnd_busy cyc %0d: got %b want %b", cyc, busy, (exp_q.size() > 0));
            end
            checks++;
            if (stall_cycles !== 16'(m_cnt16) || b_stall_cycles !== 4'(m_cnt4)) begin
                errors++;
                $display("FAIL rnd_count cyc %0d: got %0d/%0d want %0d/%0d",
                         cyc, stall_cycles, b_stall_cycles, m_cnt16, m_cnt4);
            end

            // Advance the model to the state after the coming rising edge.
            if (clr) begin
                m_cnt16 = 0;
                m_cnt4  = 0;
            end else if ((exp_q.size() > 0) && st && !hd) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (m_launch) void'(exp_q.pop_front());
            if (m_acc) exp_q.push_back(p_d);
            m_ready = (exp_q.size() < 2);
            keep = p_v && !m_acc;
        end
    endtask

    initial begin
        rst = 1'b1; src_valid = 1'b0; src_data = '0;
        fifo_in_stall = 1'b0; tx_hold = 1'b0; stall_cnt_clr = 1'b0;
        test_reset();
        test_back_to_back();
        test_stall();
        test_hold();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
